// File: rtl/iram_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-RAM refill controller.
// The line geometry helper keeps the offset derivation in one place.
package iram_ctrl_pkg;

    localparam int line_words = 4;

    typedef enum logic [1:0] {
        IRAM_IDLE,
        IRAM_REQ,
        IRAM_WAIT,
        IRAM_HOLD
    } iram_state_t;

    // Byte-offset width of one cache line: word index bits plus two byte bits.
    function automatic int line_off(input int words);
        return $clog2(words) + 2;
    endfunction

endpackage

// File: rtl/iram_ctrl.sv
// I-cache refill responder: on a miss it reads one aligned line from instruction
// memory word by word and hands each word to the fetch unit with a one-cycle pulse.
module iram_ctrl
    import iram_ctrl_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = line_words
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_miss,
    input  logic [PC_W-1:0]   ram_address,
    output logic [WORD_W-1:0] mem_word,
    output logic              word_ready,
    output logic              refill_busy,
    output logic [PC_W-1:0]   mem_addr,
    output logic              mem_re,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    localparam int                CNT_W = $clog2(LINE_WORDS);
    localparam int                OFF   = line_off(LINE_WORDS);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(LINE_WORDS - 1);
    localparam logic [PC_W-1:0]   OFF_MASK = PC_W'((1 << OFF) - 1);

    iram_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PC_W-1:0]   r_base;
    logic              r_abort;
    logic [WORD_W-1:0] r_mem_word;
    logic              r_word_ready;
    logic              r_busy;
    logic [PC_W-1:0]   r_mem_addr;
    logic              r_mem_re;

    logic [PC_W-1:0]   w_line_base;
    logic [PC_W-1:0]   w_word_addr;
    logic              w_abort;

    assign w_line_base = ram_address & ~OFF_MASK;
    assign w_word_addr = r_base + PC_W'({r_cnt, 2'b00});
    // A miss dropped in the same cycle the data returns still counts as an abort.
    assign w_abort     = r_abort | ~i_miss;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state      <= IRAM_IDLE;
            r_cnt        <= '0;
            r_base       <= '0;
            r_abort      <= 1'b0;
            r_mem_word   <= '0;
            r_word_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_re     <= 1'b0;
        end else begin
            r_word_ready <= 1'b0;
            r_mem_re     <= 1'b0;
            case (r_state)
                IRAM_IDLE: begin
                    if (i_miss) begin
                        r_base  <= w_line_base;
                        r_cnt   <= '0;
                        r_abort <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= IRAM_REQ;
                    end
                end
                IRAM_REQ: begin
                    // No read is outstanding here, so an abort can leave at once.
                    if (!i_miss) begin
                        r_busy  <= 1'b0;
                        r_state <= IRAM_IDLE;
                    end else begin
                        r_mem_re   <= 1'b1;
                        r_mem_addr <= w_word_addr;
                        r_state    <= IRAM_WAIT;
                    end
                end
                IRAM_WAIT: begin
                    if (!i_miss) begin
                        r_abort <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        if (w_abort) begin
                            r_busy  <= 1'b0;
                            r_state <= IRAM_IDLE;
                        end else begin
                            r_mem_word   <= mem_rdata;
                            r_word_ready <= 1'b1;
                            if (r_cnt == LAST) begin
                                r_busy  <= 1'b0;
                                r_state <= IRAM_HOLD;
                            end else begin
                                r_cnt   <= r_cnt + 1'b1;
                                r_state <= IRAM_REQ;
                            end
                        end
                    end
                end
                IRAM_HOLD: begin
                    // Stay until the core drops the miss so the same line is not refetched.
                    if (!i_miss) begin
                        r_state <= IRAM_IDLE;
                    end
                end
                default: r_state <= IRAM_IDLE;
            endcase
        end
    end

    assign mem_word    = r_mem_word;
    assign word_ready  = r_word_ready;
    assign refill_busy = r_busy;
    assign mem_addr    = r_mem_addr;
    assign mem_re      = r_mem_re;

endmodule

// File: tb/tb_iram_ctrl.sv
// Self-checking bench for iram_ctrl: behavioural latency-L memory plus a line-level
// reference model of addresses, data and pulse timing.
module tb_iram_ctrl;
    import iram_ctrl_pkg::*;

    localparam int PC_W       = 32;
    localparam int WORD_W     = 32;
    localparam int LW         = line_words;
    localparam int LINE_BYTES = 4 * LW;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              i_miss = 1'b0;
    logic [PC_W-1:0]   ram_address = '0;
    logic [WORD_W-1:0] mem_rdata = '0;
    logic              mem_rvalid = 1'b0;
    logic [WORD_W-1:0] mem_word;
    logic              word_ready;
    logic              refill_busy;
    logic [PC_W-1:0]   mem_addr;
    logic              mem_re;

    iram_ctrl #(.PC_W(PC_W), .WORD_W(WORD_W), .LINE_WORDS(LW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .i_miss     (i_miss),
        .ram_address(ram_address),
        .mem_word   (mem_word),
        .word_ready (word_ready),
        .refill_busy(refill_busy),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 2;
    bit          force_rv = 1'b0;
    int          n_fire   = 0;
    logic [31:0] seed;

    logic [31:0] re_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    bit          wr_busy_q[$];
    logic [31:0] last_mw;
    bit          mw_valid = 1'b0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        re_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        wr_busy_q.delete();
    endtask

    // Output monitor: logs strobes/pulses 1 time unit after each edge.
    always @(posedge clk) begin
        bit rst_now;
        rst_now = !nrst;
        cyc++;
        #1;
        if (mem_re === 1'b1) re_addr_q.push_back(mem_addr);
        if (word_ready === 1'b1) begin
            wr_data_q.push_back(mem_word);
            wr_cyc_q.push_back(cyc);
            wr_busy_q.push_back(refill_busy);
        end
        if (rst_now) begin
            last_mw  = mem_word;
            mw_valid = 1'b1;
        end else if (mw_valid) begin
            if (word_ready !== 1'b1) check_val("mw_hold", 64'(mem_word), 64'(last_mw));
            last_mw = mem_word;
        end
    end

    // Memory model: a read strobe seen at a negedge is answered lat negedges later.
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    always @(negedge clk) begin
        bit          fire;
        logic [31:0] fa;
        fire = 1'b0;
        fa   = '0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                fire = 1'b1;
                fa   = pend_addr;
                pend = 1'b0;
                n_fire++;
            end
        end
        if (mem_re === 1'b1) begin
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_addr = mem_addr;
        end
        mem_rvalid = fire | force_rv;
        mem_rdata  = fire ? mem_data(fa) : $urandom;
    end

    task automatic wait_wr(input int n, input int budget, input bit scramble, input string tag);
        while (wr_data_q.size() < n && budget > 0) begin
            @(negedge clk);
            if (scramble) ram_address = $urandom;
            budget--;
        end
        check_val({tag, "_timeout"}, 64'(wr_data_q.size() >= n), 64'd1);
    endtask

    task automatic wait_re(input int n, input int budget, input string tag);
        while (re_addr_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_val({tag, "_timeout"}, 64'(re_addr_q.size() >= n), 64'd1);
    endtask

    // Full-line refill against the reference: aligned addresses in order, memory
    // contents as data, first pulse L+2 edges after acceptance, then every L+2.
    task automatic refill(input logic [31:0] addr, input int L, input bit scramble, input string tag);
        logic [31:0] base;
        int          k;
        lat  = L;
        base = addr & ~32'(LINE_BYTES - 1);
        @(negedge clk);
        clear_logs();
        i_miss      = 1'b1;
        ram_address = addr;
        k           = cyc + 1;
        wait_wr(LW, LW * (L + 2) + 20, scramble, tag);
        check_val({tag, "_nre"}, 64'(re_addr_q.size()), 64'(LW));
        for (int i = 0; i < LW; i++) begin
            if (i < re_addr_q.size())
                check_val($sformatf("%s_addr%0d", tag, i), 64'(re_addr_q[i]), 64'(base + 32'(4 * i)));
            if (i < wr_data_q.size()) begin
                check_val($sformatf("%s_data%0d", tag, i), 64'(wr_data_q[i]),
                          64'(mem_data(base + 32'(4 * i))));
                check_val($sformatf("%s_cyc%0d", tag, i), 64'(wr_cyc_q[i]),
                          64'(k + L + 2 + i * (L + 2)));
                check_val($sformatf("%s_busy%0d", tag, i), 64'(wr_busy_q[i]), 64'(i < LW - 1));
            end
        end
    endtask

    initial begin
        int n0;
        seed = $urandom;

        nrst        = 1'b0;
        i_miss      = 1'b1;
        force_rv    = 1'b1;
        ram_address = 32'h48;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val($sformatf("rst_wr%0d", i), 64'(word_ready), 64'd0);
            check_val($sformatf("rst_re%0d", i), 64'(mem_re), 64'd0);
            check_val($sformatf("rst_busy%0d", i), 64'(refill_busy), 64'd0);
            check_val($sformatf("rst_mw%0d", i), 64'(mem_word), 64'd0);
        end
        i_miss   = 1'b0;
        force_rv = 1'b0;
        @(negedge clk);
        nrst = 1'b1;

        refill(32'h0000_0048, 2, 1'b0, "line");

        repeat (10) @(negedge clk);
        check_val("hold_nre", 64'(re_addr_q.size()), 64'(LW));
        check_val("hold_busy", 64'(refill_busy), 64'd0);
        i_miss = 1'b0;
        refill(32'h0000_0100, 2, 1'b0, "rearm");

        i_miss = 1'b0;
        repeat (2) @(negedge clk);
        lat = 2;
        n0  = n_fire;
        clear_logs();
        i_miss      = 1'b1;
        ram_address = 32'h2000_0014;
        wait_wr(1, 30, 1'b0, "abort_w1");
        wait_re(2, 30, "abort_r2");
        i_miss = 1'b0;
        repeat (12) @(negedge clk);
        check_val("abort_nre", 64'(re_addr_q.size()), 64'd2);
        check_val("abort_nwr", 64'(wr_data_q.size()), 64'd1);
        check_val("abort_fire", 64'(n_fire - n0), 64'd2);
        check_val("abort_busy", 64'(refill_busy), 64'd0);
        refill($urandom, 2, 1'b1, "post_abort");

        i_miss = 1'b0;
        repeat (2) @(negedge clk);
        lat = 2;
        n0  = n_fire;
        clear_logs();
        i_miss      = 1'b1;
        ram_address = 32'h3000_0020;
        wait_wr(2, 30, 1'b0, "rmid_w2");
        @(negedge clk);
        nrst   = 1'b0;
        i_miss = 1'b0;
        clear_logs();
        @(negedge clk);
        nrst = 1'b1;
        check_val("rmid_wr", 64'(word_ready), 64'd0);
        check_val("rmid_busy", 64'(refill_busy), 64'd0);
        check_val("rmid_re", 64'(mem_re), 64'd0);
        check_val("rmid_mw", 64'(mem_word), 64'd0);
        repeat (8) @(negedge clk);
        check_val("rmid_stale_nwr", 64'(wr_data_q.size()), 64'd0);
        check_val("rmid_stale_fire", 64'(n_fire - n0), 64'd3);
        refill(32'h3000_0020, 2, 1'b0, "rmid_refill");

        i_miss = 1'b0;
        refill(32'hFFFF_FFF0, 1, 1'b0, "lat1");
        i_miss = 1'b0;
        refill(32'hFFFF_FFF0, 7, 1'b0, "lat7");

        for (int t = 0; t < 6; t++) begin
            i_miss = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            refill($urandom, int'($urandom_range(1, 5)), 1'b1, $sformatf("rnd%0d", t));
        end

        i_miss = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
